// File: rtl/trap_ctrl.sv
// Multi-source trap/interrupt controller: synchronised edge-triggered IRQ lines,
// fixed priority (ecall first, then lowest line), direct/vectored dispatch, mret return.
module trap_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2,
  parameter int IRQ_BASE    = 16,
  parameter int ECALL_CODE  = 11
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               ecall,
  input  logic               mret,
  input  logic               hold,
  input  logic               mie_global,
  input  logic [NUM_IRQ-1:0] mie,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    cur_pc,
  output logic               trap_take,
  output logic               trap_ret,
  output logic               trapping,
  output logic [XLEN-1:0]    trap_vector,
  output logic [XLEN-1:0]    mcause,
  output logic [XLEN-1:0]    mepc,
  output logic [NUM_IRQ-1:0] mip,
  output logic               double_trap
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {IDLE, TRAP} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] pq_q, pq_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               trap_take_q, trap_take_d;
  logic               trap_ret_q, trap_ret_d;
  logic [XLEN-1:0]    trap_vector_q, trap_vector_d;
  logic [XLEN-1:0]    mcause_q, mcause_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic               double_trap_q, double_trap_d;

  logic [NUM_IRQ-1:0] sq;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clear_mask;
  logic               irq_found;
  logic [IDX_W-1:0]   irq_idx;
  logic [XLEN-1:0]    irq_code;
  logic [XLEN-1:0]    base_addr;
  logic               take_ecall;
  logic               take_irq;
  logic               do_ret;

  assign sq       = sync_q[SYNC_STAGES-1];
  assign eligible = pending_q & mie;

  // Lowest-index enabled pending line wins.
  always_comb begin
    irq_found = 1'b0;
    irq_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        irq_found = 1'b1;
        irq_idx   = i[IDX_W-1:0];
      end
    end
  end

  assign irq_code  = XLEN'(IRQ_BASE) + XLEN'(irq_idx);
  assign base_addr = {mtvec[XLEN-1:2], 2'b00};

  assign take_ecall = (state_q == IDLE) && !hold && ecall;
  assign take_irq   = (state_q == IDLE) && !hold && !ecall && mie_global && irq_found;
  assign do_ret     = (state_q == TRAP) && !hold && mret;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_ecall || take_irq) state_d = TRAP;
      TRAP:    if (do_ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses self-clear; holding registers only change on a take.
  always_comb begin
    trap_take_d   = take_ecall || take_irq;
    trap_ret_d    = do_ret;
    trap_vector_d = trap_vector_q;
    mcause_d      = mcause_q;
    mepc_d        = mepc_q;
    clear_mask    = '0;
    double_trap_d = double_trap_q || ((state_q == TRAP) && ecall);
    if (take_ecall) begin
      mcause_d      = XLEN'(ECALL_CODE);
      mepc_d        = cur_pc;
      trap_vector_d = base_addr;
    end else if (take_irq) begin
      mcause_d            = {1'b1, irq_code[XLEN-2:0]};
      mepc_d              = cur_pc;
      trap_vector_d       = (mtvec[1:0] == 2'b01) ? base_addr + (irq_code << 2) : base_addr;
      clear_mask[irq_idx] = 1'b1;
    end
  end

  // A fresh edge on the line being taken keeps it pending.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], irq_in};
    pq_d      = sq;
    pending_d = (pending_q & ~clear_mask) | (sq & ~pq_q);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      sync_q        <= '0;
      pq_q          <= '0;
      pending_q     <= '0;
      trap_take_q   <= 1'b0;
      trap_ret_q    <= 1'b0;
      trap_vector_q <= '0;
      mcause_q      <= '0;
      mepc_q        <= '0;
      double_trap_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      pq_q          <= pq_d;
      pending_q     <= pending_d;
      trap_take_q   <= trap_take_d;
      trap_ret_q    <= trap_ret_d;
      trap_vector_q <= trap_vector_d;
      mcause_q      <= mcause_d;
      mepc_q        <= mepc_d;
      double_trap_q <= double_trap_d;
    end
  end

  assign trapping    = (state_q == TRAP);
  assign trap_take   = trap_take_q;
  assign trap_ret    = trap_ret_q;
  assign trap_vector = trap_vector_q;
  assign mcause      = mcause_q;
  assign mepc        = mepc_q;
  assign mip         = pending_q;
  assign double_trap = double_trap_q;

endmodule
